// File: rtl/pcie_cfg_mgmt_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pcie_cfg_mgmt_pkg
// Purpose  : Shared widths and FSM state encoding for the cfg_mgmt responder.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package pcie_cfg_mgmt_pkg;

  localparam int CFG_ADDR_W = 10;
  localparam int CFG_FUNC_W = 8;
  localparam int CFG_DATA_W = 32;
  localparam int CFG_BE_W   = CFG_DATA_W / 8;
  localparam int CFG_CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2,
    ST_GAP  = 2'd3
  } cfg_state_e;

endpackage : pcie_cfg_mgmt_pkg
`default_nettype wire

// File: rtl/pcie_cfg_mgmt_regfile.sv
`default_nettype none
// ============================================================================
// Module   : pcie_cfg_mgmt_regfile
// Purpose  : Per-function config dword storage. Byte-enabled synchronous
//            write, combinational read, range decode, read-only ID dword 0.
// Ports    : clk/rst_n        clock, async active-low reset
//            we_i             commit write this cycle (gated by writable_o)
//            func_i, addr_i   target function / dword address
//            wdata_i, be_i    write data and byte enables
//            rdata_o          read data (0 when out of range)
//            in_range_o       function and address are backed
//            writable_o       in range and not the read-only dword 0
// Revision : 1.0 - initial release
// ============================================================================
module pcie_cfg_mgmt_regfile
  import pcie_cfg_mgmt_pkg::*;
#(
  parameter int          NUM_FUNC  = 4,
  parameter int          REG_COUNT = 16,
  parameter logic [15:0] VENDOR_ID = 16'h1234,
  parameter logic [15:0] DEVICE_ID = 16'h1001
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we_i,
  input  logic [CFG_FUNC_W-1:0] func_i,
  input  logic [CFG_ADDR_W-1:0] addr_i,
  input  logic [CFG_DATA_W-1:0] wdata_i,
  input  logic [CFG_BE_W-1:0]   be_i,
  output logic [CFG_DATA_W-1:0] rdata_o,
  output logic                  in_range_o,
  output logic                  writable_o
);

  localparam int DEPTH = NUM_FUNC * REG_COUNT;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CFG_DATA_W-1:0] mem_q [DEPTH];
  logic [IDX_W-1:0]      w_idx;

  assign in_range_o = (func_i < CFG_FUNC_W'(NUM_FUNC)) &&
                      (addr_i < CFG_ADDR_W'(REG_COUNT));
  assign writable_o = in_range_o && (addr_i != '0);
  // Flat index; only meaningful while in_range_o is set.
  assign w_idx      = IDX_W'(func_i) * IDX_W'(REG_COUNT) + IDX_W'(addr_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i && writable_o) begin
      for (int b = 0; b < CFG_BE_W; b++) begin
        if (be_i[b]) begin
          mem_q[w_idx][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  // Dword 0 never reads storage: the IDs are hard-wired through this mux.
  always_comb begin
    rdata_o = '0;
    if (in_range_o) begin
      if (addr_i == '0) begin
        rdata_o = {DEVICE_ID, VENDOR_ID};
      end else begin
        rdata_o = mem_q[w_idx];
      end
    end
  end

endmodule : pcie_cfg_mgmt_regfile
`default_nettype wire

// File: rtl/pcie_cfg_mgmt_responder.sv
`default_nettype none
// ============================================================================
// Module   : pcie_cfg_mgmt_responder
// Purpose  : Completer for the PCIe cfg_mgmt dword read/write port. Captures
//            a request, waits RESP_LATENCY cycles, pulses done (with read
//            data or a committed write), then idles one gap cycle.
// Ports    : clk, rst_n                       clock, async active-low reset
//            cfg_mgmt_addr/function_number    request target
//            cfg_mgmt_write/read              requests, held until done
//            cfg_mgmt_write_data/byte_enable  write payload
//            cfg_mgmt_read_data               read data, nonzero only with done
//            cfg_mgmt_read_write_done         one-cycle completion pulse
//            cfg_wr_event/func/addr           committed-write notification
//            status_error_proto               sticky read+write collision
// Revision : 1.0 - initial release
// ============================================================================
module pcie_cfg_mgmt_responder
  import pcie_cfg_mgmt_pkg::*;
#(
  parameter int          NUM_FUNC     = 4,
  parameter int          REG_COUNT    = 16,
  parameter int          RESP_LATENCY = 2,
  parameter logic [15:0] VENDOR_ID    = 16'h1234,
  parameter logic [15:0] DEVICE_ID    = 16'h1001
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CFG_ADDR_W-1:0] cfg_mgmt_addr,
  input  logic [CFG_FUNC_W-1:0] cfg_mgmt_function_number,
  input  logic                  cfg_mgmt_write,
  input  logic [CFG_DATA_W-1:0] cfg_mgmt_write_data,
  input  logic [CFG_BE_W-1:0]   cfg_mgmt_byte_enable,
  input  logic                  cfg_mgmt_read,
  output logic [CFG_DATA_W-1:0] cfg_mgmt_read_data,
  output logic                  cfg_mgmt_read_write_done,
  output logic                  cfg_wr_event,
  output logic [CFG_FUNC_W-1:0] cfg_wr_func,
  output logic [CFG_ADDR_W-1:0] cfg_wr_addr,
  output logic                  status_error_proto
);

  cfg_state_e            state_q;
  logic [CFG_CNT_W-1:0]  cnt_q;
  logic [CFG_ADDR_W-1:0] addr_q;
  logic [CFG_FUNC_W-1:0] func_q;
  logic [CFG_DATA_W-1:0] wdata_q;
  logic [CFG_BE_W-1:0]   be_q;
  logic                  is_wr_q;
  logic [CFG_DATA_W-1:0] rdata_q;
  logic                  done_q;
  logic                  wr_event_q;
  logic [CFG_FUNC_W-1:0] wr_func_q;
  logic [CFG_ADDR_W-1:0] wr_addr_q;
  logic                  err_q;

  logic                  w_idle;
  logic                  w_req;
  logic                  w_finish;
  logic [CFG_ADDR_W-1:0] w_addr;
  logic [CFG_FUNC_W-1:0] w_func;
  logic [CFG_DATA_W-1:0] w_wdata;
  logic [CFG_BE_W-1:0]   w_be;
  logic                  w_is_wr;
  logic [CFG_DATA_W-1:0] w_rf_rdata;
  logic                  w_rf_in_range;
  logic                  w_rf_writable;

  assign w_idle = (state_q == ST_IDLE);
  assign w_req  = cfg_mgmt_read | cfg_mgmt_write;

  // With a latency of 1 the transaction completes on the acceptance edge,
  // before the capture registers hold it, so the live inputs feed the
  // register file while idle and the frozen copies otherwise.
  assign w_addr  = w_idle ? cfg_mgmt_addr            : addr_q;
  assign w_func  = w_idle ? cfg_mgmt_function_number : func_q;
  assign w_wdata = w_idle ? cfg_mgmt_write_data      : wdata_q;
  assign w_be    = w_idle ? cfg_mgmt_byte_enable     : be_q;
  assign w_is_wr = w_idle ? cfg_mgmt_write           : is_wr_q;

  // Edge on which the transaction takes effect and done is registered.
  assign w_finish = (w_idle && w_req && (RESP_LATENCY == 1)) ||
                    ((state_q == ST_WAIT) && (cnt_q == CFG_CNT_W'(1)));

  pcie_cfg_mgmt_regfile #(
    .NUM_FUNC  (NUM_FUNC),
    .REG_COUNT (REG_COUNT),
    .VENDOR_ID (VENDOR_ID),
    .DEVICE_ID (DEVICE_ID)
  ) u_regfile (
    .clk        (clk),
    .rst_n      (rst_n),
    .we_i       (w_finish && w_is_wr),
    .func_i     (w_func),
    .addr_i     (w_addr),
    .wdata_i    (w_wdata),
    .be_i       (w_be),
    .rdata_o    (w_rf_rdata),
    .in_range_o (w_rf_in_range),
    .writable_o (w_rf_writable)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      func_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      is_wr_q    <= 1'b0;
      rdata_q    <= '0;
      done_q     <= 1'b0;
      wr_event_q <= 1'b0;
      wr_func_q  <= '0;
      wr_addr_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      // Pulses default low; they are raised only on the finish edge.
      done_q     <= 1'b0;
      wr_event_q <= 1'b0;
      rdata_q    <= '0;

      case (state_q)
        ST_IDLE: begin
          if (w_req) begin
            addr_q  <= cfg_mgmt_addr;
            func_q  <= cfg_mgmt_function_number;
            wdata_q <= cfg_mgmt_write_data;
            be_q    <= cfg_mgmt_byte_enable;
            // A simultaneous read+write is serviced as a write.
            is_wr_q <= cfg_mgmt_write;
            if (cfg_mgmt_read && cfg_mgmt_write) begin
              err_q <= 1'b1;
            end
            if (RESP_LATENCY == 1) begin
              state_q <= ST_DONE;
            end else begin
              cnt_q   <= CFG_CNT_W'(RESP_LATENCY - 1);
              state_q <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          cnt_q <= cnt_q - CFG_CNT_W'(1);
          if (cnt_q == CFG_CNT_W'(1)) begin
            state_q <= ST_DONE;
          end
        end
        ST_DONE: state_q <= ST_GAP;
        ST_GAP:  state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase

      if (w_finish) begin
        done_q <= 1'b1;
        if (!w_is_wr) begin
          rdata_q <= w_rf_rdata;
        end else if (w_rf_writable) begin
          wr_event_q <= 1'b1;
          wr_func_q  <= w_func;
          wr_addr_q  <= w_addr;
        end
      end
    end
  end

  assign cfg_mgmt_read_data       = rdata_q;
  assign cfg_mgmt_read_write_done = done_q;
  assign cfg_wr_event             = wr_event_q;
  assign cfg_wr_func              = wr_func_q;
  assign cfg_wr_addr              = wr_addr_q;
  assign status_error_proto       = err_q;

endmodule : pcie_cfg_mgmt_responder
`default_nettype wire

// File: tb/tb_pcie_cfg_mgmt_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_pcie_cfg_mgmt_responder
// Purpose  : Directed self-checking bench. Instance u_dut_l2 uses latency 2,
//            u_dut_l1 latency 1; sel routes the requests to one of them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pcie_cfg_mgmt_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel;
  logic [9:0]  addr;
  logic [7:0]  func;
  logic        wr;
  logic        rd;
  logic [31:0] wdata;
  logic [3:0]  be;

  always #5 clk = ~clk;

  wire        rd0 = rd & ~sel;
  wire        wr0 = wr & ~sel;
  wire        rd1 = rd & sel;
  wire        wr1 = wr & sel;

  wire [31:0] d0_rdata, d1_rdata;
  wire        d0_done, d1_done, d0_ev, d1_ev, d0_err, d1_err;
  wire [7:0]  d0_wf, d1_wf;
  wire [9:0]  d0_wa, d1_wa;

  pcie_cfg_mgmt_responder #(.RESP_LATENCY(2)) u_dut_l2 (
    .clk(clk), .rst_n(rst_n),
    .cfg_mgmt_addr(addr), .cfg_mgmt_function_number(func),
    .cfg_mgmt_write(wr0), .cfg_mgmt_write_data(wdata),
    .cfg_mgmt_byte_enable(be), .cfg_mgmt_read(rd0),
    .cfg_mgmt_read_data(d0_rdata), .cfg_mgmt_read_write_done(d0_done),
    .cfg_wr_event(d0_ev), .cfg_wr_func(d0_wf), .cfg_wr_addr(d0_wa),
    .status_error_proto(d0_err)
  );

  pcie_cfg_mgmt_responder #(.RESP_LATENCY(1)) u_dut_l1 (
    .clk(clk), .rst_n(rst_n),
    .cfg_mgmt_addr(addr), .cfg_mgmt_function_number(func),
    .cfg_mgmt_write(wr1), .cfg_mgmt_write_data(wdata),
    .cfg_mgmt_byte_enable(be), .cfg_mgmt_read(rd1),
    .cfg_mgmt_read_data(d1_rdata), .cfg_mgmt_read_write_done(d1_done),
    .cfg_wr_event(d1_ev), .cfg_wr_func(d1_wf), .cfg_wr_addr(d1_wa),
    .status_error_proto(d1_err)
  );

  wire [31:0] o_rdata = sel ? d1_rdata : d0_rdata;
  wire        o_done  = sel ? d1_done  : d0_done;
  wire        o_ev    = sel ? d1_ev    : d0_ev;
  wire        o_err   = sel ? d1_err   : d0_err;
  wire [7:0]  o_wf    = sel ? d1_wf    : d0_wf;
  wire [9:0]  o_wa    = sel ? d1_wa    : d0_wa;

  int compared   = 0;
  int mismatched = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One request: driven just after a clock edge, held until one cycle past
  // done (two when hold2 is set), then released.
  task automatic txn(input string tag, input logic r, input logic w,
                     input logic [7:0] f, input logic [9:0] a,
                     input logic [31:0] d, input logic [3:0] b,
                     input int lat, input logic [31:0] exp_rd,
                     input logic exp_ev, input bit hold2);
    int n;
    n = 0;
    @(posedge clk); #1;
    rd = r; wr = w; func = f; addr = a; wdata = d; be = b;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!o_done && n < 20);
    chk({tag, "/latency"}, o_done ? n : -1, lat);
    chk({tag, "/rdata"}, o_rdata, exp_rd);
    chk({tag, "/wr_event"}, {31'd0, o_ev}, {31'd0, exp_ev});
    if (exp_ev) begin
      chk({tag, "/wr_func"}, {24'd0, o_wf}, {24'd0, f});
      chk({tag, "/wr_addr"}, {22'd0, o_wa}, {22'd0, a});
    end
    @(posedge clk); #1;
    chk({tag, "/gap_done"}, {31'd0, o_done}, 32'd0);
    if (hold2) begin
      @(posedge clk); #1;
      chk({tag, "/idle_done"}, {31'd0, o_done}, 32'd0);
    end
    rd = 1'b0; wr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; sel = 1'b0; rd = 1'b0; wr = 1'b0;
    func = '0; addr = '0; wdata = '0; be = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset/done",  {31'd0, o_done}, 32'd0);
    chk("reset/rdata", o_rdata, 32'd0);
    chk("reset/ev",    {31'd0, o_ev}, 32'd0);
    chk("reset/err",   {31'd0, o_err}, 32'd0);
    chk("reset/wf_wa", {14'd0, o_wf, o_wa}, 32'd0);
    rst_n = 1'b1;

    // Latency 2
    txn("t1_rd_f0a0", 1, 0, 8'd0, 10'd0, 32'h0, 4'h0, 2, 32'h1001_1234, 0, 1);
    txn("t2_wr_f1a5", 0, 1, 8'd1, 10'd5, 32'hA5A5_5A5A, 4'b0101, 2, 32'h0, 1, 0);
    txn("t2_rd_f1a5", 1, 0, 8'd1, 10'd5, 32'h0, 4'h0, 2, 32'h00A5_005A, 0, 0);
    txn("be0_wr_f1a5", 0, 1, 8'd1, 10'd5, 32'hFFFF_FFFF, 4'b0000, 2, 32'h0, 1, 0);
    txn("be0_rd_f1a5", 1, 0, 8'd1, 10'd5, 32'h0, 4'h0, 2, 32'h00A5_005A, 0, 0);
    txn("t3_wr_f2a0", 0, 1, 8'd2, 10'd0, 32'h0, 4'hF, 2, 32'h0, 0, 0);
    chk("t3_held_func", {24'd0, o_wf}, 32'd1);
    chk("t3_held_addr", {22'd0, o_wa}, 32'd5);
    txn("t3_rd_f2a0", 1, 0, 8'd2, 10'd0, 32'h0, 4'h0, 2, 32'h1001_1234, 0, 0);
    txn("t4_rd_f4a3", 1, 0, 8'd4, 10'd3, 32'h0, 4'h0, 2, 32'h0, 0, 0);
    txn("t4_rd_f0a16", 1, 0, 8'd0, 10'd16, 32'h0, 4'h0, 2, 32'h0, 0, 0);
    txn("t4_wr_f4a1", 0, 1, 8'd4, 10'd1, 32'h1111_1111, 4'hF, 2, 32'h0, 0, 0);
    txn("edge_wr_f3a15", 0, 1, 8'd3, 10'd15, 32'h1234_5678, 4'hF, 2, 32'h0, 1, 0);
    txn("edge_rd_f3a15", 1, 0, 8'd3, 10'd15, 32'h0, 4'h0, 2, 32'h1234_5678, 0, 0);
    chk("t5_err_before", {31'd0, o_err}, 32'd0);
    txn("t5_rdwr_f0a2", 1, 1, 8'd0, 10'd2, 32'hDEAD_BEEF, 4'hF, 2, 32'h0, 1, 0);
    chk("t5_err_set", {31'd0, o_err}, 32'd1);
    txn("t5_rd_f0a2", 1, 0, 8'd0, 10'd2, 32'h0, 4'h0, 2, 32'hDEAD_BEEF, 0, 0);
    chk("t5_err_sticky", {31'd0, o_err}, 32'd1);

    // Reset while a write to f0 a3 is waiting
    @(posedge clk); #1;
    func = 8'd0; addr = 10'd3; wdata = 32'hCAFE_F00D; be = 4'hF; wr = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("t6_done_in_reset", {31'd0, o_done}, 32'd0);
    @(posedge clk); #1;
    chk("t6_done_after_edge", {31'd0, o_done}, 32'd0);
    chk("t6_err_cleared", {31'd0, o_err}, 32'd0);
    wr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    txn("t6_rd_f0a3", 1, 0, 8'd0, 10'd3, 32'h0, 4'h0, 2, 32'h0, 0, 0);
    txn("t6_rd_f0a2", 1, 0, 8'd0, 10'd2, 32'h0, 4'h0, 2, 32'h0, 0, 0);

    // Latency 1
    sel = 1'b1;
    txn("l1_rd_f0a0", 1, 0, 8'd0, 10'd0, 32'h0, 4'h0, 1, 32'h1001_1234, 0, 1);
    txn("l1_wr_f1a5", 0, 1, 8'd1, 10'd5, 32'hA5A5_5A5A, 4'b0101, 1, 32'h0, 1, 0);
    txn("l1_rd_f1a5", 1, 0, 8'd1, 10'd5, 32'h0, 4'h0, 1, 32'h00A5_005A, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_pcie_cfg_mgmt_responder
`default_nettype wire
